store_unit: RTL

Buffered store path for the uPower core: the write-to-memory counterpart of the register load/writeback path. Accepts store instructions (stb/sth/stw/std) carrying an effective address and the RS register value. Converts each into big-endian byte-lane data plus byte enables, queues it in a small FIFO, and drains it to data memory over a req/ack handshake. Sits between the register read stage and the data memory; misaligned stores that cross a doubleword are split into two beats.

---
 rtl/upower_pkg.sv | 34 +++
 rtl/store_fifo.sv | 50 +++++
 rtl/store_unit.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/upower_pkg.sv
// upower_pkg: shared store-path definitions (opcodes, drain states, queue entry,
// opcode-to-size decode).
package upower_pkg;

    localparam logic [5:0] OP_STB = 6'd38;
    localparam logic [5:0] OP_STH = 6'd44;
    localparam logic [5:0] OP_STW = 6'd36;
    localparam logic [5:0] OP_STD = 6'd62;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BEAT0,
        ST_BEAT1
    } drain_state_t;

    // One queued store: effective address, raw RS value, size in bytes (1/2/4/8).
    typedef struct packed {
        logic [63:0] addr;
        logic [63:0] data;
        logic [3:0]  size;
    } store_entry_t;

    // Store size in bytes; 0 marks an opcode that is not a store.
    function automatic logic [3:0] size_from_op(input logic [5:0] op);
        case (op)
            OP_STB:  return 4'd1;
            OP_STH:  return 4'd2;
            OP_STW:  return 4'd4;
            OP_STD:  return 4'd8;
            default: return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/store_fifo.sv
// store_fifo: DEPTH-entry circular buffer of store entries. Exposes the head
// and the entry behind it so the drain FSM can chain beats without a bubble.
module store_fifo
    import upower_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  store_entry_t                 wr_entry,
    output store_entry_t                 head,
    output store_entry_t                 after_head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    store_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;

    // Entry storage; needs no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_entry;
    end

    // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head       = mem[rd_ptr];
    assign after_head = mem[rd_ptr + AW'(1)];

endmodule

// File: rtl/store_unit.sv
// store_unit: buffered store path. Turns stb/sth/stw/std into big-endian lane
// data plus byte enables, queues them, and drains over a req/ack handshake.
// Build option: define STORE_SPLIT_EN to split doubleword-crossing stores into
// two beats; without it such stores are dropped and flagged on align_err.
module store_unit
    import upower_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         st_valid,
    output logic                         st_ready,
    input  logic [5:0]                   st_opcode,
    input  logic [63:0]                  st_addr,
    input  logic [63:0]                  st_data,
    output logic                         mem_req,
    input  logic                         mem_ack,
    output logic [63:0]                  mem_addr,
    output logic [63:0]                  mem_wdata,
    output logic [7:0]                   mem_be,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         busy,
    output logic                         align_err
);

    localparam int unsigned CW = $clog2(DEPTH+1);

    drain_state_t  state;
    logic [3:0]    in_size;
    store_entry_t  in_entry;
    store_entry_t  head;
    store_entry_t  second;
    store_entry_t  next_entry;
    logic          accept;
    logic          push;
    logic          pop;
    logic          beat_done;
    logic          last_beat;
    logic          have_next;
    logic          load;
    logic [CW-1:0] avail;
    logic [2:0]    n_off;
    logic [63:0]   n_left;
    logic [7:0]    n_be_left;
    logic [63:0]   n_w0;
    logic [7:0]    n_be0;

    assign st_ready  = (count < CW'(DEPTH));
    assign busy      = (count != '0);
    assign accept    = st_valid && st_ready;
    assign in_size   = size_from_op(st_opcode);
    assign in_entry  = '{addr: st_addr, data: st_data, size: in_size};
    assign beat_done = mem_req && mem_ack;

`ifdef STORE_SPLIT_EN
    logic        cross_q;
    logic [63:0] w1_q;
    logic [7:0]  be1_q;
    logic        n_cross;
    logic [63:0] n_w1;
    logic [7:0]  n_be1;

    assign push      = accept && (in_size != '0);
    assign align_err = 1'b0;
    assign last_beat = (state == ST_BEAT0 && !cross_q) || (state == ST_BEAT1);
`else
    logic in_cross;

    assign in_cross  = ({1'b0, st_addr[2:0]} + in_size) > 4'd8;
    assign push      = accept && (in_size != '0) && !in_cross;
    assign last_beat = (state == ST_BEAT0);

    // Flag a rejected crossing store in the cycle after acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) align_err <= 1'b0;
        else        align_err <= accept && (in_size != '0) && in_cross;
    end
`endif

    assign pop   = beat_done && last_beat;
    assign avail = count - CW'(pop);

    // Pick the entry to load into BEAT0: the surviving queue head, or the store
    // being pushed right now when the queue drains empty, so a store into an
    // idle unit raises mem_req the very next cycle.
    always_comb begin
        have_next  = 1'b0;
        next_entry = head;
        if (avail != '0) begin
            have_next  = 1'b1;
            next_entry = pop ? second : head;
        end else if (push) begin
            have_next  = 1'b1;
            next_entry = in_entry;
        end
        load = have_next && ((state == ST_IDLE) || pop);
    end

    // Lane generation: left-justify the stored bytes, then shift right by the
    // byte offset; whatever spills past byte 7 belongs to the second beat.
    always_comb begin
        n_off     = next_entry.addr[2:0];
        n_left    = next_entry.data << {4'd8 - next_entry.size, 3'b000};
        n_be_left = 8'hFF << (4'd8 - next_entry.size);
        n_w0      = n_left >> {n_off, 3'b000};
        n_be0     = n_be_left >> n_off;
`ifdef STORE_SPLIT_EN
        n_cross   = ({1'b0, n_off} + next_entry.size) > 4'd8;
        n_w1      = n_left << {4'd8 - {1'b0, n_off}, 3'b000};
        n_be1     = n_be_left << (4'd8 - {1'b0, n_off});
`endif
    end

    // Drain FSM with registered beat outputs held stable until acked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
`ifdef STORE_SPLIT_EN
            cross_q   <= 1'b0;
            w1_q      <= '0;
            be1_q     <= '0;
`endif
        end else if (load) begin
            state     <= ST_BEAT0;
            mem_req   <= 1'b1;
            mem_addr  <= {next_entry.addr[63:3], 3'b000};
            mem_wdata <= n_w0;
            mem_be    <= n_be0;
`ifdef STORE_SPLIT_EN
            cross_q   <= n_cross;
            w1_q      <= n_w1;
            be1_q     <= n_be1;
`endif
        end else if (beat_done) begin
`ifdef STORE_SPLIT_EN
            if (state == ST_BEAT0 && cross_q) begin
                state     <= ST_BEAT1;
                mem_addr  <= mem_addr + 64'd8;
                mem_wdata <= w1_q;
                mem_be    <= be1_q;
            end else begin
                state   <= ST_IDLE;
                mem_req <= 1'b0;
            end
`else
            state   <= ST_IDLE;
            mem_req <= 1'b0;
`endif
        end
    end

    store_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .pop        (pop),
        .wr_entry   (in_entry),
        .head       (head),
        .after_head (second),
        .count      (count)
    );

endmodule
